// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART constants and the byte type used by the transmit FIFO slice.
package uart_pkg;
  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef logic [7:0] uart_byte_t;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host-write and transmitter-read handshake bundle around the UART TX FIFO.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 8
);
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              wr_full;
  logic              wr_afull;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;

  modport master (
    output wr_en, wr_data, tx_ready,
    input  wr_full, wr_afull, tx_valid, tx_data
  );

  modport slave (
    input  wr_en, wr_data, tx_ready,
    output wr_full, wr_afull, tx_valid, tx_data
  );
endinterface

// File: rtl/uart_tx_fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read, no reset.
module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// First-word fall-through byte FIFO feeding the UART transmitter.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W    = UART_DATA_W,
  parameter int DEPTH     = UART_FIFO_DEPTH,
  parameter int AFULL_LVL = 12,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_fifo_if.slave bus,
  input  logic          flush,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic [CW-1:0] count
);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic              ovf_r;
  logic              full_s;
  logic              valid_s;
  logic              push_s;
  logic              pop_s;
  logic              ovf_set_s;
  logic [DATA_W-1:0] rdata_s;

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (bus.wr_data),
    .raddr (rd_ptr_r),
    .rdata (rdata_s)
  );

  // Occupancy decodes and handshake qualification; flush masks push and pop.
  always_comb begin
    full_s    = (count_r == FULL_CNT);
    valid_s   = (count_r != {CW{1'b0}});
    pop_s     = 1'b0;
    push_s    = 1'b0;
    ovf_set_s = 1'b0;
    if (!flush) begin
      pop_s     = valid_s && bus.tx_ready;
      push_s    = bus.wr_en && (!full_s || pop_s);
      ovf_set_s = bus.wr_en && full_s && !pop_s;
    end else begin
      pop_s     = 1'b0;
      push_s    = 1'b0;
      ovf_set_s = 1'b0;
    end
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky overflow; a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_r <= 1'b0;
    end else if (ovf_set_s) begin
      ovf_r <= 1'b1;
    end else if (ovf_clr) begin
      ovf_r <= 1'b0;
    end
  end

  assign bus.tx_valid = valid_s;
  assign bus.tx_data  = valid_s ? rdata_s : {DATA_W{1'b0}};
  assign bus.wr_full  = full_s;
  assign bus.wr_afull = (count_r >= AFULL_CNT);
  assign ovf          = ovf_r;
  assign count        = count_r;
endmodule
